// File: rtl/spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_param                                             |
// | Description : Parametrised SPI master. Serialises a DATA_W-bit word onto   |
// |               spi_mosi with a programmable SCLK divider, SPI mode          |
// |               (CPOL/CPHA), bit order and chip-select idle time.            |
// |               Start/busy/done handshake toward the host logic.             |
// |               Optional full-duplex capture of spi_miso when the macro      |
// |               SPI_RX_EN is defined; otherwise rx_data is tied to zero.     |
// | Ports       : clk, rst (async, active high)                                |
// |               start, tx_data            - host request / word to send      |
// |               busy, done, rx_data       - host status / received word      |
// |               bit_count                 - bits remaining (DATA_W if idle)  |
// |               spi_sclk, spi_mosi, spi_cs_n, spi_miso - SPI bus             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_master_param #(
  parameter int DATA_W         = 16,
  parameter int CLK_DIV        = 2,
  parameter int CPOL           = 0,
  parameter int CPHA           = 0,
  parameter int MSB_FIRST      = 1,
  parameter int CS_IDLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DATA_W-1:0]           tx_data,
  output logic                        busy,
  output logic                        done,
  output logic                        spi_sclk,
  output logic                        spi_mosi,
  output logic                        spi_cs_n,
  input  logic                        spi_miso,
  output logic [DATA_W-1:0]           rx_data,
  output logic [$clog2(DATA_W+1)-1:0] bit_count
);

  localparam int BC_W    = $clog2(DATA_W + 1);
  localparam int HALF_W  = $clog2(2 * DATA_W);
  localparam int CNT_MAX = (CLK_DIV > CS_IDLE_CYCLES) ? CLK_DIV : CS_IDLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic              IDLE_LVL  = (CPOL != 0);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_W - 1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CS_IDLE_CYCLES - 1);
  localparam logic [BC_W-1:0]   BC_FULL   = BC_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [HALF_W-1:0]   r_half;
  logic [DATA_W-1:0]   r_tx_shift;

  logic                w_tick;
  logic                w_accept;
  logic                w_edge;
  logic                w_lead;
  logic                w_trail;
  logic                w_sample;
  logic                w_shift;
  logic                w_hold_end;
  logic [HALF_W-1:0]   w_half_next;

  // Next bit to present on mosi, and the register after it has been consumed.
  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  // r_cnt times each CLK_DIV-long phase (SETUP, every half-period, HOLD) and
  // the chip-select idle time in GAP.
  assign w_tick     = (r_cnt == DIV_LAST);
  assign w_accept   = (r_state == IDLE) && start;
  assign w_hold_end = (r_state == HOLD) && w_tick;

  // An SCLK edge happens at the start of every half-period: the end of SETUP
  // opens half-period 0, each XFER tick opens the next one. The end of the
  // last half-period leads into HOLD with SCLK already back at idle level.
  assign w_edge      = w_tick && ((r_state == SETUP) ||
                                  ((r_state == XFER) && (r_half != LAST_HALF)));
  assign w_half_next = (r_state == SETUP) ? '0 : r_half + 1'b1;
  assign w_lead      = w_edge && !w_half_next[0];
  assign w_trail     = w_edge &&  w_half_next[0];
  assign w_sample    = (CPHA != 0) ? w_trail : w_lead;
  // CPHA=0 already drove bit 0 at accept, so the final trailing edge has
  // nothing left to shift and the last bit is held through HOLD.
  assign w_shift     = (CPHA != 0) ? w_lead : (w_trail && (w_half_next != LAST_HALF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = SETUP;
      end
      SETUP: begin
        if (w_tick) w_state_next = XFER;
      end
      XFER: begin
        if (w_tick && (r_half == LAST_HALF)) w_state_next = HOLD;
      end
      HOLD: begin
        if (w_tick) w_state_next = GAP;
      end
      GAP: begin
        done = (r_cnt == '0);
        if (r_cnt == GAP_LAST) w_state_next = IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_half     <= '0;
      r_tx_shift <= '0;
      spi_sclk   <= IDLE_LVL;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      bit_count  <= BC_FULL;
    end else begin
      // cs_n is registered from the next state so the pin never glitches.
      spi_cs_n <= (w_state_next == IDLE) || (w_state_next == GAP);

      if ((r_state == IDLE) || (r_state != w_state_next)) begin
        r_cnt <= '0;
      end else if (r_state == GAP) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      end

      if (w_edge) begin
        r_half   <= w_half_next;
        spi_sclk <= ~spi_sclk;
      end

      if (w_accept) begin
        if (CPHA == 0) begin
          spi_mosi   <= head_bit(tx_data);
          r_tx_shift <= advance(tx_data);
        end else begin
          r_tx_shift <= tx_data;
        end
      end else if (w_shift) begin
        spi_mosi   <= head_bit(r_tx_shift);
        r_tx_shift <= advance(r_tx_shift);
      end else if (w_hold_end) begin
        spi_mosi <= 1'b0;
      end

      if (w_hold_end) begin
        bit_count <= BC_FULL;
      end else if (w_sample) begin
        bit_count <= bit_count - 1'b1;
      end
    end
  end

`ifdef SPI_RX_EN
  logic [DATA_W-1:0] r_rx_shift;

  // Received bits are assembled in the same order they are transmitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shift <= '0;
      rx_data    <= '0;
    end else begin
      if (w_sample) begin
        r_rx_shift <= (MSB_FIRST != 0) ? {r_rx_shift[DATA_W-2:0], spi_miso}
                                       : {spi_miso, r_rx_shift[DATA_W-1:1]};
      end
      if (w_hold_end) begin
        rx_data <= r_rx_shift;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_param                                          |
// | Description : Self-checking bench for spi_master_param. Three instances:   |
// |               0: defaults; 1: CPOL=1 CPHA=1 with miso looped to mosi;      |
// |               2: DATA_W=8 LSB first CLK_DIV=1 CS_IDLE_CYCLES=2.            |
// |               Honours SPI_RX_EN for the expected rx_data.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master_param;

  localparam int CFG_DW   [3] = '{16, 16, 8};
  localparam int CFG_CD   [3] = '{2, 2, 1};
  localparam int CFG_CPOL [3] = '{0, 1, 0};
  localparam int CFG_CPHA [3] = '{0, 1, 0};
  localparam int CFG_MSB  [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miso_tog = 1'b0;
  logic        miso_c;
  logic        start_v [3];
  logic [15:0] tx_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        sclk_v  [3];
  logic        mosi_v  [3];
  logic        cs_v    [3];
  logic [15:0] rx_a, rx_b;
  logic [7:0]  rx_c;
  logic [4:0]  bc_a, bc_b;
  logic [3:0]  bc_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) miso_tog <= ~miso_tog;

`ifdef SPI_RX_EN
  assign miso_c = mosi_v[2];
`else
  assign miso_c = miso_tog;
`endif

  spi_master_param u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .tx_data(tx_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .spi_sclk(sclk_v[0]), .spi_mosi(mosi_v[0]),
    .spi_cs_n(cs_v[0]), .spi_miso(mosi_v[0]), .rx_data(rx_a), .bit_count(bc_a)
  );

  spi_master_param #(.CPOL(1), .CPHA(1)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .tx_data(tx_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .spi_sclk(sclk_v[1]), .spi_mosi(mosi_v[1]),
    .spi_cs_n(cs_v[1]), .spi_miso(mosi_v[1]), .rx_data(rx_b), .bit_count(bc_b)
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0), .CS_IDLE_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .tx_data(tx_v[2][7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .spi_sclk(sclk_v[2]), .spi_mosi(mosi_v[2]),
    .spi_cs_n(cs_v[2]), .spi_miso(miso_c), .rx_data(rx_c), .bit_count(bc_c)
  );

  function automatic logic [15:0] rx_of(input int k);
    return (k == 0) ? rx_a : (k == 1) ? rx_b : {8'h00, rx_c};
  endfunction

  function automatic logic [4:0] bc_of(input int k);
    return (k == 0) ? bc_a : (k == 1) ? bc_b : {1'b0, bc_c};
  endfunction

  // Reference: the bit sequence on the wire, first bit at position DATA_W-1.
  function automatic logic [15:0] model_bits(input int k, input logic [15:0] d);
    logic [15:0] r = '0;
    for (int i = 0; i < CFG_DW[k]; i++)
      r = {r[14:0], (CFG_MSB[k] != 0) ? d[CFG_DW[k]-1-i] : d[i]};
    return r;
  endfunction

  function automatic logic [15:0] model_rx(input logic [15:0] d);
`ifdef SPI_RX_EN
    return d;
`else
    return (d & 16'h0000);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int k);
    int w = 0;
    @(negedge clk);
    while (busy_v[k] !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %b for inst %0d", busy_v[k], k);
    end
  endtask

  // Observes one transfer from the cycle after accept up to the first GAP cycle.
  task automatic check_xfer(input int k, input logic [15:0] data,
                            input logic [15:0] exp_bits, input int n_cs);
    int          cs_err = 0, done_err = 0, busy_err = 0, bc_err = 0, nbits = 0;
    logic [15:0] got  = '0;
    logic        cpol = (CFG_CPOL[k] != 0);
    logic        slvl = (CFG_CPHA[k] != 0) ? cpol : ~cpol;
    logic        prev = cpol;
    for (int t = 0; t <= n_cs; t++) begin
      @(negedge clk);
      if (cs_v[k]   !== (t == n_cs)) cs_err++;
      if (done_v[k] !== (t == n_cs)) done_err++;
      if (busy_v[k] !== 1'b1)        busy_err++;
      if (sclk_v[k] !== prev && sclk_v[k] === slvl) begin
        got = {got[14:0], mosi_v[k]};
        nbits++;
        if (bc_of(k) !== 5'(CFG_DW[k] - nbits)) bc_err++;
      end
      prev = sclk_v[k];
      if (t == 0) check("sclk_idle_setup", sclk_v[k], cpol);
    end
    check("cs_window_errs", cs_err, 0);
    check("done_pulse_errs", done_err, 0);
    check("busy_errs", busy_err, 0);
    check("bit_count_errs", bc_err, 0);
    check("sample_edges", nbits, CFG_DW[k]);
    check("mosi_bits", got, exp_bits);
    check("sclk_idle_after", sclk_v[k], cpol);
    check("mosi_gap", mosi_v[k], 0);
    check("bit_count_reload", bc_of(k), CFG_DW[k]);
    check("rx_data", rx_of(k), model_rx(data));
  endtask

  task automatic run_xfer(input int k, input logic [15:0] data,
                          input logic [15:0] exp_bits, input int n_cs);
    wait_idle(k);
    tx_v[k]    = data;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    tx_v[k]    = 16'($urandom);  // must not disturb the latched word
    check_xfer(k, data, exp_bits, n_cs);
  endtask

  typedef struct {
    int          k;
    logic [15:0] data;
    logic [15:0] exp_bits;
    int          n_cs;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [5];
    int          falls;
    int          w;
    int          k;
    logic [15:0] d;

    vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 68};
    vecs[1] = '{1, 16'h1234, 16'h1234, 68};
    vecs[2] = '{2, 16'h0001, 16'h0080, 18};
    vecs[3] = '{2, 16'h00B4, 16'h002D, 18};
    vecs[4] = '{0, 16'h8001, 16'h8001, 68};

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      tx_v[i]    = '0;
    end

    // Reset state while rst is held.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_cs_n", cs_v[i], 1);
      check("rst_sclk", sclk_v[i], CFG_CPOL[i]);
      check("rst_mosi", mosi_v[i], 0);
      check("rst_busy", busy_v[i], 0);
      check("rst_done", done_v[i], 0);
      check("rst_bit_count", bc_of(i), CFG_DW[i]);
      check("rst_rx_data", rx_of(i), 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_xfer(vecs[i].k, vecs[i].data, vecs[i].exp_bits, vecs[i].n_cs);

    // start held high: two back-to-back words, cs_n high for exactly 2 cycles.
    wait_idle(0);
    tx_v[0]    = 16'h00FF;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_v[0] = 16'hFF00;
    check_xfer(0, 16'h00FF, 16'h00FF, 68);
    @(negedge clk);
    check("b2b_cs_high_2nd", cs_v[0], 1);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check_xfer(0, 16'hFF00, 16'hFF00, 68);

    // start pulses while busy (mid-transfer and in GAP) must be ignored.
    wait_idle(0);
    tx_v[0]    = 16'h3C5A;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    fork
      check_xfer(0, 16'h3C5A, 16'h3C5A, 68);
      begin
        repeat (10) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (57) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
      end
    join
    falls = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cs_v[0] !== 1'b1) falls++;
    end
    check("no_extra_xfer", falls, 0);

    // Asynchronous reset mid-transfer at bit_count = 7.
    wait_idle(0);
    tx_v[0]    = 16'h0F0F;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    w = 0;
    while (bc_of(0) !== 5'd7 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("reach_bc7_busy", busy_v[0], 1);
    rst = 1'b1;
    #1;
    check("midrst_cs_n", cs_v[0], 1);
    check("midrst_sclk", sclk_v[0], 0);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_bit_count", bc_of(0), 16);
    check("midrst_mosi", mosi_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    run_xfer(0, 16'hBEEF, 16'hBEEF, 68);

    // Randomised transfers against the reference model.
    for (int i = 0; i < 12; i++) begin
      k = i % 3;
      d = 16'($urandom);
      if (k == 2) d = d & 16'h00FF;
      run_xfer(k, d, model_bits(k, d), (2 + 2 * CFG_DW[k]) * CFG_CD[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
